// File: rtl/ram_scan_controller_pkg.sv
// rtl/ram_scan_controller_pkg.sv - shared state encodings and frame defaults for the RAM scanner
// Purpose: FSM state type and the default geometry/widths of the 160x120 frame.
// Ports: none (package).
package ram_scan_controller_pkg;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_WAIT    = 2'd1,
        ST_ISSUE   = 2'd2,
        ST_CAPTURE = 2'd3
    } scan_state_e;

    localparam int DEF_COLS        = 160;
    localparam int DEF_ROWS        = 120;
    localparam int DEF_X_BITS      = 8;
    localparam int DEF_Y_BITS      = 7;
    localparam int DEF_ADDR_BITS   = 15;
    localparam int DEF_COLOUR_BITS = 3;
    localparam int DEF_DIV_BITS    = 28;

endpackage

// File: rtl/ram_scan_controller_if.sv
// rtl/ram_scan_controller_if.sv - control, writer, RAM and VGA signal bundle of the scanner
// Purpose: groups every non-clock/reset signal of ram_scan_controller.
// Ports: slave modport = scanner view (control/writer/rdata in; ack/RAM/VGA/status out);
//        master modport = environment view (mirror image).
interface ram_scan_controller_if
    import ram_scan_controller_pkg::*;
#(
    parameter int X_BITS      = DEF_X_BITS,
    parameter int Y_BITS      = DEF_Y_BITS,
    parameter int ADDR_BITS   = DEF_ADDR_BITS,
    parameter int COLOUR_BITS = DEF_COLOUR_BITS,
    parameter int DIV_BITS    = DEF_DIV_BITS
) ();

    logic                   start;
    logic [DIV_BITS-1:0]    period;
    logic                   wr_req;
    logic [ADDR_BITS-1:0]   wr_addr;
    logic [COLOUR_BITS-1:0] wr_data;
    logic                   wr_ack;
    logic [ADDR_BITS-1:0]   ram_addr;
    logic [COLOUR_BITS-1:0] ram_wdata;
    logic                   ram_we;
    logic [COLOUR_BITS-1:0] ram_rdata;
    logic [X_BITS-1:0]      vga_x;
    logic [Y_BITS-1:0]      vga_y;
    logic [COLOUR_BITS-1:0] vga_colour;
    logic                   vga_plot;
    logic                   busy;
    logic                   done;

    modport slave (
        input  start, period, wr_req, wr_addr, wr_data, ram_rdata,
        output wr_ack, ram_addr, ram_wdata, ram_we,
        output vga_x, vga_y, vga_colour, vga_plot, busy, done
    );

    modport master (
        output start, period, wr_req, wr_addr, wr_data, ram_rdata,
        input  wr_ack, ram_addr, ram_wdata, ram_we,
        input  vga_x, vga_y, vga_colour, vga_plot, busy, done
    );

endinterface

// File: rtl/ram_scan_controller_rate_divider.sv
// rtl/ram_scan_controller_rate_divider.sv - loadable up-counter that wraps to zero on match
// Purpose: paces the scanner's WAIT state; tick is high while the count equals d.
// Ports: clock, clear (async reset), clr (sync zero), en (count), d (match value), tick (out).
module ram_scan_controller_rate_divider #(
    parameter int DIV_BITS = 28
) (
    input  logic                clock,
    input  logic                clear,
    input  logic                clr,
    input  logic                en,
    input  logic [DIV_BITS-1:0] d,
    output logic                tick
);

    logic [DIV_BITS-1:0] cnt_q, cnt_d;

    assign tick = (cnt_q == d);

    always_comb begin
        cnt_d = cnt_q;
        if (clr) begin
            cnt_d = '0;
        end else if (en) begin
            cnt_d = tick ? '0 : cnt_q + DIV_BITS'(1);
        end
    end

    always_ff @(posedge clock or posedge clear) begin
        if (clear) cnt_q <= '0;
        else       cnt_q <= cnt_d;
    end

endmodule

// File: rtl/ram_scan_controller.sv
// rtl/ram_scan_controller.sv - paced full-frame scan of the frame RAM into the VGA adapter
// Purpose: walks x/y over COLS x ROWS, reads each pixel through the shared RAM port and
//          emits a registered plot strobe; the game-logic writer owns the port except in ISSUE.
// Ports: clock, clear (async active-high reset), bus (ram_scan_controller_if.slave).
module ram_scan_controller
    import ram_scan_controller_pkg::*;
#(
    parameter int COLS        = DEF_COLS,
    parameter int ROWS        = DEF_ROWS,
    parameter int X_BITS      = DEF_X_BITS,
    parameter int Y_BITS      = DEF_Y_BITS,
    parameter int ADDR_BITS   = DEF_ADDR_BITS,
    parameter int COLOUR_BITS = DEF_COLOUR_BITS,
    parameter int DIV_BITS    = DEF_DIV_BITS
) (
    input  logic                  clock,
    input  logic                  clear,
    ram_scan_controller_if.slave  bus
);

    scan_state_e            state_q, state_d;
    logic [X_BITS-1:0]      x_q, x_d;
    logic [Y_BITS-1:0]      y_q, y_d;
    logic [DIV_BITS-1:0]    period_q, period_d;
    logic [X_BITS-1:0]      vga_x_q, vga_x_d;
    logic [Y_BITS-1:0]      vga_y_q, vga_y_d;
    logic [COLOUR_BITS-1:0] vga_colour_q, vga_colour_d;
    logic                   vga_plot_q, vga_plot_d;
    logic                   done_q, done_d;
    logic                   busy_q, busy_d;

    logic                   div_clr, div_en, div_tick;
    logic                   scan_owns_port;
    logic                   last_pixel;
    logic [ADDR_BITS-1:0]   scan_addr;

    ram_scan_controller_rate_divider #(.DIV_BITS(DIV_BITS)) u_div (
        .clock (clock),
        .clear (clear),
        .clr   (div_clr),
        .en    (div_en),
        .d     (period_q),
        .tick  (div_tick)
    );

    assign last_pixel = (x_q == X_BITS'(COLS - 1)) && (y_q == Y_BITS'(ROWS - 1));
    assign scan_addr  = ADDR_BITS'(y_q) * ADDR_BITS'(COLS) + ADDR_BITS'(x_q);

    // The scanner only needs the port for its single address cycle; the writer gets
    // every other cycle, and read data in CAPTURE already reflects the ISSUE address.
    assign scan_owns_port = (state_q == ST_ISSUE);
    assign bus.ram_addr   = scan_owns_port ? scan_addr : bus.wr_addr;
    assign bus.ram_we     = !scan_owns_port && bus.wr_req;
    assign bus.ram_wdata  = bus.wr_data;
    assign bus.wr_ack     = bus.ram_we;

    assign bus.vga_x      = vga_x_q;
    assign bus.vga_y      = vga_y_q;
    assign bus.vga_colour = vga_colour_q;
    assign bus.vga_plot   = vga_plot_q;
    assign bus.done       = done_q;
    assign bus.busy       = busy_q;

    always_comb begin
        state_d      = state_q;
        x_d          = x_q;
        y_d          = y_q;
        period_d     = period_q;
        vga_x_d      = vga_x_q;
        vga_y_d      = vga_y_q;
        vga_colour_d = vga_colour_q;
        vga_plot_d   = 1'b0;
        done_d       = 1'b0;
        busy_d       = busy_q;
        div_clr      = 1'b0;
        div_en       = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (bus.start) begin
                    state_d  = ST_WAIT;
                    x_d      = '0;
                    y_d      = '0;
                    period_d = bus.period;
                    busy_d   = 1'b1;
                    div_clr  = 1'b1;
                end
            end
            ST_WAIT: begin
                // Divider self-clears on the match cycle, so the next WAIT starts at zero.
                div_en = 1'b1;
                if (div_tick) state_d = ST_ISSUE;
            end
            ST_ISSUE: begin
                state_d = ST_CAPTURE;
            end
            ST_CAPTURE: begin
                vga_colour_d = bus.ram_rdata;
                vga_x_d      = x_q;
                vga_y_d      = y_q;
                vga_plot_d   = 1'b1;
                if (last_pixel) begin
                    done_d  = 1'b1;
                    busy_d  = 1'b0;
                    state_d = ST_IDLE;
                end else begin
                    state_d = ST_WAIT;
                    if (x_q == X_BITS'(COLS - 1)) begin
                        x_d = '0;
                        y_d = y_q + Y_BITS'(1);
                    end else begin
                        x_d = x_q + X_BITS'(1);
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clock or posedge clear) begin
        if (clear) begin
            state_q      <= ST_IDLE;
            x_q          <= '0;
            y_q          <= '0;
            period_q     <= '0;
            vga_x_q      <= '0;
            vga_y_q      <= '0;
            vga_colour_q <= '0;
            vga_plot_q   <= 1'b0;
            done_q       <= 1'b0;
            busy_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            x_q          <= x_d;
            y_q          <= y_d;
            period_q     <= period_d;
            vga_x_q      <= vga_x_d;
            vga_y_q      <= vga_y_d;
            vga_colour_q <= vga_colour_d;
            vga_plot_q   <= vga_plot_d;
            done_q       <= done_d;
            busy_q       <= busy_d;
        end
    end

endmodule

// File: tb/tb_ram_scan_controller.sv
// tb/tb_ram_scan_controller.sv - scoreboard bench for ram_scan_controller on a 4x2 frame
module tb_ram_scan_controller;

    localparam int COLS        = 4;
    localparam int ROWS        = 2;
    localparam int X_BITS      = 8;
    localparam int Y_BITS      = 7;
    localparam int ADDR_BITS   = 3;
    localparam int COLOUR_BITS = 3;
    localparam int DIV_BITS    = 28;
    localparam int NPIX        = COLS * ROWS;

    typedef struct {
        int     x;
        int     y;
        int     colour;
        int     last;
        longint cyc;
    } exp_t;

    logic   clock;
    logic   clear;
    logic   ram_init;
    longint cyc;
    int     n_cmp;
    int     n_bad;
    int     done_cnt;
    exp_t   exp_q[$];
    logic [COLOUR_BITS-1:0] mem [NPIX];

    ram_scan_controller_if #(
        .X_BITS(X_BITS), .Y_BITS(Y_BITS), .ADDR_BITS(ADDR_BITS),
        .COLOUR_BITS(COLOUR_BITS), .DIV_BITS(DIV_BITS)
    ) bus ();

    ram_scan_controller #(
        .COLS(COLS), .ROWS(ROWS), .X_BITS(X_BITS), .Y_BITS(Y_BITS),
        .ADDR_BITS(ADDR_BITS), .COLOUR_BITS(COLOUR_BITS), .DIV_BITS(DIV_BITS)
    ) dut (
        .clock (clock),
        .clear (clear),
        .bus   (bus)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    initial cyc = 0;
    always @(posedge clock) cyc <= cyc + 1;

    // Synchronous single-port RAM: read-before-write, data one cycle after address.
    always @(posedge clock) begin
        if (ram_init) begin
            for (int i = 0; i < NPIX; i++) mem[i] <= COLOUR_BITS'(i);
        end else if (bus.ram_we) begin
            mem[bus.ram_addr] <= bus.ram_wdata;
        end
        bus.ram_rdata <= mem[bus.ram_addr];
    end

    task automatic check(input string name, input longint act, input longint exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Monitor: every plot strobe pops one expected pixel.
    always @(negedge clock) begin
        if (!clear) begin
            if (bus.vga_plot) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_plot", 1, 0);
                end else begin
                    exp_t e;
                    e = exp_q.pop_front();
                    check("plot_x", bus.vga_x, e.x);
                    check("plot_y", bus.vga_y, e.y);
                    check("plot_colour", bus.vga_colour, e.colour);
                    check("plot_cycle", cyc, e.cyc);
                    check("plot_done", bus.done, e.last);
                    check("plot_busy", bus.busy, e.last ? 0 : 1);
                    check("x_in_range", (bus.vga_x < COLS) ? 1 : 0, 1);
                end
            end else if (bus.done) begin
                check("done_without_plot", 1, 0);
            end
            if (bus.done) done_cnt++;
        end
    end

    task automatic push_frame(input longint s, input int p, input int count,
                              input int ov_addr, input int ov_val);
        exp_t e;
        for (int n = 0; n < count; n++) begin
            e.x      = n % COLS;
            e.y      = n / COLS;
            e.colour = (n == ov_addr) ? ov_val : n;
            e.last   = (n == NPIX - 1) ? 1 : 0;
            e.cyc    = s + longint'((n + 1) * (p + 3));
            exp_q.push_back(e);
        end
    endtask

    // Returns the cycle stamp of the edge that accepted start; caller is #1 past that edge.
    task automatic start_scan(input int p, output longint s);
        @(negedge clock);
        bus.period = DIV_BITS'(p);
        bus.start  = 1'b1;
        @(posedge clock);
        #1;
        s = cyc;
        bus.start = 1'b0;
    endtask

    task automatic wait_frame(input int budget);
        for (int i = 0; i < budget && exp_q.size() != 0; i++) @(negedge clock);
        check("frame_complete_pending", exp_q.size(), 0);
        repeat (4) @(negedge clock);
    endtask

    task automatic reload_ram();
        @(negedge clock);
        ram_init = 1'b1;
        @(negedge clock);
        ram_init = 1'b0;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        longint s;
        int     d0;
        n_cmp = 0;
        n_bad = 0;
        done_cnt = 0;
        ram_init = 1'b0;
        clear = 1'b1;
        bus.start = 1'b0;
        bus.period = '0;
        bus.wr_req = 1'b0;
        bus.wr_addr = '0;
        bus.wr_data = '0;

        // Reset state.
        repeat (3) @(negedge clock);
        check("rst_vga_x", bus.vga_x, 0);
        check("rst_vga_y", bus.vga_y, 0);
        check("rst_colour", bus.vga_colour, 0);
        check("rst_plot", bus.vga_plot, 0);
        check("rst_done", bus.done, 0);
        check("rst_busy", bus.busy, 0);
        clear = 1'b0;
        reload_ram();
        repeat (3) @(negedge clock);

        // 1: period 0, pitch 3, includes the row wrap (3,0) -> (0,1).
        start_scan(0, s);
        push_frame(s, 0, NPIX, -1, 0);
        check("busy_after_start", bus.busy, 1);
        wait_frame(200);
        check("idle_busy", bus.busy, 0);

        // 2: period 4, pitch 7, last plot 56 cycles after start.
        start_scan(4, s);
        push_frame(s, 4, NPIX, -1, 0);
        wait_frame(200);

        // 3: writer holds the port through WAIT and ISSUE of pixel 0.
        start_scan(4, s);
        push_frame(s, 4, NPIX, 5, 2);
        bus.wr_req  = 1'b1;
        bus.wr_addr = 3'd5;
        bus.wr_data = 3'd2;
        for (int k = 0; k < 6; k++) begin
            @(negedge clock);
            check("wr_ack", bus.wr_ack, (k < 5) ? 1 : 0);
            if (k == 5) begin
                check("issue_ram_we", bus.ram_we, 0);
                check("issue_ram_addr", bus.ram_addr, 0);
            end else begin
                check("wait_ram_addr", bus.ram_addr, 5);
            end
        end
        @(posedge clock);
        #1;
        bus.wr_req = 1'b0;
        wait_frame(200);
        reload_ram();

        // 4: a second start mid-frame with another period is ignored.
        d0 = done_cnt;
        start_scan(1, s);
        push_frame(s, 1, NPIX, -1, 0);
        repeat (10) @(negedge clock);
        bus.period = DIV_BITS'(9);
        bus.start  = 1'b1;
        @(negedge clock);
        bus.start  = 1'b0;
        wait_frame(200);
        repeat (10) @(negedge clock);
        check("single_done", done_cnt - d0, 1);

        // 5: clear between the plots of pixels 2 and 3.
        d0 = done_cnt;
        start_scan(0, s);
        push_frame(s, 0, 3, -1, 0);
        repeat (10) @(posedge clock);
        #2;
        check("pre_clear_x", bus.vga_x, 2);
        clear = 1'b1;
        #1;
        check("clr_vga_x", bus.vga_x, 0);
        check("clr_colour", bus.vga_colour, 0);
        check("clr_plot", bus.vga_plot, 0);
        check("clr_done", bus.done, 0);
        check("clr_busy", bus.busy, 0);
        @(negedge clock);
        @(negedge clock);
        clear = 1'b0;
        repeat (20) @(negedge clock);
        check("clr_pending", exp_q.size(), 0);
        check("clr_no_done", done_cnt - d0, 0);

        // 5b: fresh scan after clear starts again at (0,0).
        start_scan(0, s);
        push_frame(s, 0, NPIX, -1, 0);
        wait_frame(200);
        check("final_done_count", done_cnt - d0, 1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
